// File: rtl/wb_result_checker.sv
// wb_result_checker: shadows register-file writebacks during a run, then sweeps them
// against a programmed expected table and mask and reports pass/fail.
module wb_result_checker #(
    parameter int XLEN    = 32,
    parameter int NREGS   = 32,
    parameter int AW      = 5,
    parameter int TIMEOUT = 200,
    localparam int FW     = $clog2(NREGS + 1),
    localparam int CW     = $clog2(TIMEOUT + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            halt,
    input  logic            wb_we,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            exp_we,
    input  logic [AW-1:0]   exp_addr,
    input  logic [XLEN-1:0] exp_data,
    input  logic            exp_chk,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [FW-1:0]   fail_count,
    output logic [AW-1:0]   first_fail,
    output logic [CW-1:0]   cycles
);
    typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cycles_q, cycles_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [FW-1:0]   fail_q, fail_d;
    logic [AW-1:0]   first_q, first_d;
    logic [XLEN-1:0] shadow_q [NREGS];
    logic [XLEN-1:0] exp_q [NREGS];
    logic [NREGS-1:0] mask_q;
    logic            open_w, launch_w, wb_ok_w, exp_ok_w, mism_w;

    assign open_w   = (state_q == IDLE) || (state_q == DONE);
    assign launch_w = open_w && start;
    // index 0 is hardwired zero, so its shadow is never written
    assign wb_ok_w  = (state_q == RUN) && wb_we && (wb_addr != '0) && (32'(wb_addr) < NREGS);
    assign exp_ok_w = open_w && exp_we && (32'(exp_addr) < NREGS);
    assign mism_w   = mask_q[idx_q] && (shadow_q[idx_q] != exp_q[idx_q]);

    always_comb begin
        state_d  = state_q;
        cycles_d = cycles_q;
        idx_d    = idx_q;
        fail_d   = fail_q;
        first_d  = first_q;
        if (launch_w) begin
            state_d  = RUN;
            cycles_d = '0;
            idx_d    = '0;
            fail_d   = '0;
            first_d  = '0;
        end
        if (state_q == RUN) begin
            cycles_d = cycles_q + 1'b1;
            state_d  = (halt || 32'(cycles_q) == TIMEOUT - 1) ? CHECK : RUN;
        end
        if (state_q == CHECK) begin
            idx_d   = idx_q + 1'b1;
            fail_d  = mism_w ? fail_q + 1'b1 : fail_q;
            first_d = (mism_w && fail_q == '0) ? idx_q : first_q;
            state_d = (32'(idx_q) == NREGS - 1) ? DONE : CHECK;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cycles_q <= '0;
            idx_q    <= '0;
            fail_q   <= '0;
            first_q  <= '0;
            mask_q   <= '0;
            for (int i = 0; i < NREGS; i++) begin
                shadow_q[i] <= '0;
                exp_q[i]    <= '0;
            end
        end else begin
            state_q  <= state_d;
            cycles_q <= cycles_d;
            idx_q    <= idx_d;
            fail_q   <= fail_d;
            first_q  <= first_d;
            if (exp_ok_w) begin
                exp_q[exp_addr]  <= exp_data;
                mask_q[exp_addr] <= exp_chk;
            end
            if (launch_w) begin
                for (int i = 0; i < NREGS; i++) shadow_q[i] <= '0;
            end else if (wb_ok_w) begin
                shadow_q[wb_addr] <= wb_data;
            end
        end
    end

    assign busy       = (state_q == RUN) || (state_q == CHECK);
    assign done       = (state_q == DONE);
    assign pass       = done && (fail_q == '0);
    assign fail_count = fail_q;
    assign first_fail = first_q;
    assign cycles     = cycles_q;
endmodule

// File: tb/tb_wb_result_checker.sv
// tb_wb_result_checker: directed table runs, corner sequences and randomized runs
// checked against a register-level reference model.
module tb_wb_result_checker;
    localparam int XLEN = 32, NREGS = 32, AW = 5, TIMEOUT = 200;
    localparam int FW = $clog2(NREGS + 1), CW = $clog2(TIMEOUT + 1);

    logic clk = 0, rst = 0, start = 0, halt = 0, wb_we = 0, exp_we = 0, exp_chk = 0;
    logic [AW-1:0] wb_addr = '0, exp_addr = '0;
    logic [XLEN-1:0] wb_data = '0, exp_data = '0;
    logic busy, done, pass;
    logic [FW-1:0] fail_count;
    logic [AW-1:0] first_fail;
    logic [CW-1:0] cycles;

    int checks = 0, errors = 0;
    logic [XLEN-1:0] m_exp [NREGS];
    logic [XLEN-1:0] m_sh [NREGS];
    bit m_mask [NREGS];

    typedef struct {int len; logic [31:0] v3; logic [31:0] v5; int f; int ff; bit p;} vec_t;
    vec_t tbl [5];

    always #5 clk = ~clk;

    wb_result_checker #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .start(start), .halt(halt),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .exp_we(exp_we), .exp_addr(exp_addr), .exp_data(exp_data), .exp_chk(exp_chk),
        .busy(busy), .done(done), .pass(pass), .fail_count(fail_count),
        .first_fail(first_fail), .cycles(cycles)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < NREGS; i++) begin
            m_exp[i] = '0; m_sh[i] = '0; m_mask[i] = 0;
        end
    endtask

    task automatic prog(input int a, input logic [31:0] d, input bit c);
        exp_we = 1; exp_addr = AW'(a); exp_data = d; exp_chk = c;
        tick();
        exp_we = 0;
        if (a < NREGS) begin
            m_exp[a] = d; m_mask[a] = c;
        end
    endtask

    task automatic prog_base();
        prog(0, 0, 1); prog(1, 2, 1); prog(2, 4, 1); prog(3, 2, 1);
        prog(4, 2, 1); prog(5, 6, 1); prog(6, 4, 1); prog(7, 0, 0);
    endtask

    task automatic model_result(output int f, output int ff);
        f = 0; ff = 0;
        for (int i = 0; i < NREGS; i++)
            if (m_mask[i] && m_sh[i] !== m_exp[i]) begin
                if (f == 0) ff = i;
                f++;
            end
    endtask

    // One full run of len RUN cycles (halted early when len < TIMEOUT), then the sweep.
    task automatic run(input int len, input bit directed, input logic [31:0] v3, input logic [31:0] v5);
        int busy_n;
        bit we;
        int a;
        logic [31:0] d;
        start = 1;
        tick();
        start = 0; exp_we = 0;
        for (int i = 0; i < NREGS; i++) m_sh[i] = '0;
        busy_n = busy ? 1 : 0;
        for (int k = 0; k < len; k++) begin
            if (directed) begin
                we = 1;
                if (k == len - 1) begin a = 6; d = 4; end
                else if (k < 5) begin
                    a = k + 1;
                    d = (k == 0) ? 2 : (k == 1) ? 4 : (k == 2) ? v3 : (k == 3) ? 2 : v5;
                end
                else if (k % 2 == 1) begin a = 0; d = 5; end
                else begin a = 7; d = $urandom; end
            end else begin
                we = $urandom_range(0, 3) != 0;
                a = $urandom_range(0, NREGS - 1);
                d = $urandom_range(0, 3);
            end
            wb_we = we; wb_addr = AW'(a); wb_data = d;
            halt = (k == len - 1) && (len < TIMEOUT);
            if (k == len / 2) begin
                start = 1; exp_we = 1; exp_addr = 4; exp_data = 32'hdead; exp_chk = 1;
            end
            tick();
            start = 0; exp_we = 0; halt = 0;
            if (we && a != 0 && a < NREGS) m_sh[a] = d;
            busy_n += busy ? 1 : 0;
        end
        chk("cycles_at_end_of_run", cycles, len);
        for (int j = 1; j <= NREGS; j++) begin
            wb_we = 1; wb_addr = 1; wb_data = 32'hbad; halt = 1;
            tick();
            busy_n += busy ? 1 : 0;
            if (j == NREGS - 1) chk("done_not_early", done, 0);
        end
        chk("done_after_sweep", done, 1);
        chk("busy_cycles", busy_n, len + NREGS);
        tick();
        wb_we = 0; halt = 0;
    endtask

    initial begin
        int f, ff;
        model_clear();
        #3;
        chk("reset_busy", busy, 0); chk("reset_done", done, 0); chk("reset_pass", pass, 0);
        chk("reset_fail_count", fail_count, 0); chk("reset_first_fail", first_fail, 0);
        chk("reset_cycles", cycles, 0);
        #20 rst = 1;
        tick();
        chk("idle_done", done, 0);
        prog_base();

        tbl[0] = '{200, 2, 6, 0, 0, 1};
        tbl[1] = '{200, 9, 7, 2, 3, 0};
        tbl[2] = '{10, 2, 6, 0, 0, 1};
        tbl[3] = '{3, 2, 6, 3, 3, 0};
        tbl[4] = '{1, 2, 6, 5, 1, 0};
        for (int t = 0; t < 5; t++) begin
            run(tbl[t].len, 1, tbl[t].v3, tbl[t].v5);
            chk($sformatf("tbl%0d_fail_count", t), fail_count, tbl[t].f);
            chk($sformatf("tbl%0d_first_fail", t), first_fail, tbl[t].ff);
            chk($sformatf("tbl%0d_pass", t), pass, tbl[t].p);
            chk($sformatf("tbl%0d_cycles_held", t), cycles, tbl[t].len);
            chk($sformatf("tbl%0d_done_held", t), done, 1);
        end

        // reset in the middle of a run clears everything, including the table
        start = 1; tick(); start = 0;
        repeat (20) begin
            wb_we = 1; wb_addr = 3; wb_data = 9;
            tick();
        end
        wb_we = 0;
        #2 rst = 0;
        #1;
        chk("midrst_busy", busy, 0); chk("midrst_done", done, 0); chk("midrst_pass", pass, 0);
        chk("midrst_fail_count", fail_count, 0); chk("midrst_first_fail", first_fail, 0);
        chk("midrst_cycles", cycles, 0);
        model_clear();
        @(negedge clk) rst = 1;
        tick();
        run(TIMEOUT, 1, 9, 7);
        chk("cleared_table_pass", pass, 1);
        chk("cleared_table_fail_count", fail_count, 0);

        // reprogram in DONE, with the x2 update landing in the same cycle as start
        prog_base();
        exp_we = 1; exp_addr = 2; exp_data = 5; exp_chk = 1;
        m_exp[2] = 5; m_mask[2] = 1;
        run(TIMEOUT, 1, 2, 6);
        chk("reprog_fail_count", fail_count, 1);
        chk("reprog_first_fail", first_fail, 2);
        chk("reprog_pass", pass, 0);

        for (int r = 0; r < 12; r++) begin
            int len;
            repeat (6) prog($urandom_range(0, NREGS - 1), $urandom_range(0, 3), $urandom_range(0, 1));
            len = ($urandom_range(0, 4) == 0) ? TIMEOUT : $urandom_range(1, 40);
            run(len, 0, 0, 0);
            model_result(f, ff);
            chk($sformatf("rnd%0d_fail_count", r), fail_count, f);
            chk($sformatf("rnd%0d_first_fail", r), first_fail, ff);
            chk($sformatf("rnd%0d_pass", r), pass, f == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_result_checker.md
Name: wb_result_checker

Overview:
- Parametrised, synthesizable self-checking monitor for the pipeline regression flow. It generalises the fixed "run N cycles, compare six registers" bench check.
- Snoops the register-file writeback port and keeps a shadow copy of every architectural register.
- After a configurable cycle budget, or an early halt, it sweeps all registers against a programmed expected table and mask.
- Reports pass/fail, the mismatch count and the first failing index. Sits beside the datapath in simulation tops and FPGA smoke-test builds.

Parameters:
- XLEN, 32, data width of registers and expected values
- NREGS, 32, number of architectural registers checked (index 0 hardwired zero)
- AW, 5, register index width; must satisfy 2**AW >= NREGS
- TIMEOUT, 200, RUN-phase cycle budget before automatic check; must be >= 1

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin a run; honoured in IDLE or DONE only
- halt  in  1  end RUN early; ignored outside RUN
- wb_we  in  1  writeback enable from datapath
- wb_addr  in  AW  writeback destination index
- wb_data  in  XLEN  writeback data
- exp_we  in  1  program one expected entry; honoured in IDLE or DONE only
- exp_addr  in  AW  expected-table index
- exp_data  in  XLEN  expected value
- exp_chk  in  1  mask bit for the entry (1 = compare this register)
- busy  out  1  high in RUN or CHECK
- done  out  1  high in DONE
- pass  out  1  valid while done; 1 when fail_count == 0
- fail_count  out  clog2(NREGS+1)  number of masked registers that mismatched
- first_fail  out  AW  lowest mismatching index; 0 when none
- cycles  out  clog2(TIMEOUT+1)  RUN cycles elapsed in the last or current run

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - FSM = IDLE; all outputs 0.
  - Shadow registers, expected table and mask all cleared to 0.
- FSM states: IDLE, RUN, CHECK, DONE.
- IDLE/DONE + start:
  - Next state RUN.
  - Shadow registers, cycles, fail_count, first_fail and pass are cleared.
  - Expected table and mask are retained.
- RUN:
  - cycles increments every RUN cycle.
  - On wb_we with wb_addr != 0 and wb_addr < NREGS, the shadow register takes wb_data at the clock edge. Writes to index 0 or out-of-range indices are dropped.
  - Leave to CHECK when cycles reaches TIMEOUT-1, or on halt, whichever comes first. RUN therefore lasts at most TIMEOUT cycles.
  - A writeback in the same cycle as halt, or in the final timeout cycle, is captured.
- CHECK:
  - Index i sweeps 0..NREGS-1, one register per cycle.
  - For each i with mask[i]=1 and shadow[i] != expected[i]: increment fail_count; if it is the first mismatch, latch first_fail=i.
  - Writebacks are ignored. After index NREGS-1, go to DONE.
  - Latency from leaving RUN to done = NREGS cycles.
- DONE:
  - done=1 and pass=(fail_count==0); outputs are held stable.
  - Remains in DONE until start.
- exp_we in IDLE/DONE writes expected[exp_addr]=exp_data and mask[exp_addr]=exp_chk.
  - Out-of-range exp_addr is ignored.
  - Writes to index 0 are allowed; shadow 0 is always 0.
  - exp_we while busy is ignored.
- Simultaneous start and exp_we in IDLE/DONE: both take effect. The entry is used by the new run.
- start or exp_we during RUN/CHECK: ignored.
- Reset asserted mid-run: immediate return to IDLE with everything cleared. No partial result is reported.

Test Plan:
- Program mask/expected x1=2, x2=4, x3=2, x4=2, x5=6, x6=4; start; drive writebacks of exactly those values; no halt -> busy for TIMEOUT+NREGS cycles, cycles=200, done=1, pass=1, fail_count=0.
- Same setup but drive x5=7 and x3=9 -> done=1, pass=0, fail_count=2, first_fail=3.
- halt after 10 RUN cycles with a writeback to x6=4 in the halt cycle -> cycles=10, x6 counted as a match, done exactly NREGS cycles later.
- Writeback x0=5 with mask[0]=1, expected[0]=0 -> no mismatch. Unmasked register x7 holding garbage -> ignored, pass=1.
- Assert rst mid-RUN, then start again without reprogramming -> outputs 0 during reset. All-zero mask now gives pass=1, since the table was cleared.
- In DONE, reprogram x2=5 and start; rerun the same program -> fail_count=1, first_fail=2. exp_we issued during RUN is ignored (verify by readback of the outcome).
